// File: rtl/grf_wb_pkg.sv
// Shared types and sizing for the GRF write-back arbiter.
//   REG_AW     : GRF register address width
//   DATA_W     : data / instruction-address width
//   DEPTH      : long-channel FIFO entries (power of two)
//   STARVE_MAX : consecutive blocked cycles before a pipeline hold request
//   wb_req_t   : one write-back request {addr, data, pc}
package grf_wb_pkg;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 4;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests for the long-latency channel.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   push, push_data : enqueue request (ignored when full)
//   pop             : dequeue head (ignored when empty)
//   full, empty     : start-of-cycle occupancy flags
//   head            : current head entry, valid while !empty
module wb_fifo
  import grf_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEPTH
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  wb_req_t       mem [FIFO_DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the GRF's single write port.
// The in-order pipeline always wins; long-latency results queue in wb_fifo
// and drain on cycles the pipeline leaves free.
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   p_valid/p_addr/p_data/p_pc        : pipeline write-back request
//   l_valid/l_ready/l_addr/l_data/l_pc: long-channel request with accept
//   iss_valid/iss_addr                : long-op issue, marks destination busy
//   busy                              : per-register pending-long-result bits
//   pipe_hold                         : one-cycle request to idle the pipeline
//   hold_err                          : sticky, pipeline wrote during pipe_hold
//   wb_we/wb_addr/wb_data/wb_iaddr    : registered GRF write port
module grf_wb_arbiter
  import grf_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              p_valid,
  input  logic [REG_AW-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  input  logic [DATA_W-1:0] p_pc,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [REG_AW-1:0] l_addr,
  input  logic [DATA_W-1:0] l_data,
  input  logic [DATA_W-1:0] l_pc,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_addr,
  output logic [31:0]       busy,
  output logic              pipe_hold,
  output logic              hold_err,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_iaddr
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic          live;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  wb_req_t       l_req;
  wb_req_t       head;
  logic [CW-1:0] starve_cnt;

  logic              wb_we_nxt;
  logic [REG_AW-1:0] wb_addr_nxt;
  logic [DATA_W-1:0] wb_data_nxt;
  logic [DATA_W-1:0] wb_iaddr_nxt;
  logic [31:0]       busy_nxt;
  logic [CW-1:0]     starve_cnt_nxt;
  logic              pipe_hold_nxt;
  logic              hold_err_nxt;

  // A pipeline write to r0 is no request at all.
  assign live    = p_valid && (p_addr != '0);
  assign l_ready = !fifo_full;
  assign push    = l_valid && !fifo_full;
  assign pop     = !live && !fifo_empty;
  assign l_req   = '{addr: l_addr, data: l_data, pc: l_pc};

  wb_fifo #(.FIFO_DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (l_req),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Next-state: write port, scoreboard, starvation tracking.
  always_comb begin
    wb_we_nxt      = 1'b0;
    wb_addr_nxt    = wb_addr;
    wb_data_nxt    = wb_data;
    wb_iaddr_nxt   = wb_iaddr;
    busy_nxt       = busy;
    starve_cnt_nxt = starve_cnt;
    pipe_hold_nxt  = 1'b0;
    hold_err_nxt   = hold_err | (pipe_hold && live);

    // Arbitration: live pipeline, else FIFO head; r0 heads are dropped silently.
    if (live) begin
      wb_we_nxt    = 1'b1;
      wb_addr_nxt  = p_addr;
      wb_data_nxt  = p_data;
      wb_iaddr_nxt = p_pc;
    end else if (pop && (head.addr != '0)) begin
      wb_we_nxt    = 1'b1;
      wb_addr_nxt  = head.addr;
      wb_data_nxt  = head.data;
      wb_iaddr_nxt = head.pc;
    end

    // Clear on pop, set on issue; the decoder never lets these hit one register.
    if (pop && (head.addr != '0)) busy_nxt[head.addr] = 1'b0;
    if (iss_valid && (iss_addr != '0)) busy_nxt[iss_addr] = 1'b1;

    // A non-empty FIFO that does not pop has lost to the pipeline this cycle.
    if (fifo_empty || pop) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt == CW'(STARVE_MAX - 1)) begin
      starve_cnt_nxt = '0;
      pipe_hold_nxt  = 1'b1;
    end else begin
      starve_cnt_nxt = starve_cnt + CW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      wb_iaddr   <= '0;
      busy       <= '0;
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
      hold_err   <= 1'b0;
    end else begin
      wb_we      <= wb_we_nxt;
      wb_addr    <= wb_addr_nxt;
      wb_data    <= wb_data_nxt;
      wb_iaddr   <= wb_iaddr_nxt;
      busy       <= busy_nxt;
      starve_cnt <= starve_cnt_nxt;
      pipe_hold  <= pipe_hold_nxt;
      hold_err   <= hold_err_nxt;
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: reset values, both write paths,
// scoreboard, FIFO full/drain order, starvation hold, r0 handling and
// asynchronous reset mid-operation.
module tb_grf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic [31:0] p_pc;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_addr;
  logic [31:0] l_data;
  logic [31:0] l_pc;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [31:0] busy;
  logic        pipe_hold;
  logic        hold_err;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_iaddr;

  int total = 0;
  int bad   = 0;

  grf_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .p_valid   (p_valid),
    .p_addr    (p_addr),
    .p_data    (p_data),
    .p_pc      (p_pc),
    .l_valid   (l_valid),
    .l_ready   (l_ready),
    .l_addr    (l_addr),
    .l_data    (l_data),
    .l_pc      (l_pc),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .busy      (busy),
    .pipe_hold (pipe_hold),
    .hold_err  (hold_err),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_iaddr  (wb_iaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    p_valid = 1'b0; p_addr = '0; p_data = '0; p_pc = '0;
    l_valid = 1'b0; l_addr = '0; l_data = '0; l_pc = '0;
    iss_valid = 1'b0; iss_addr = '0;

    // Reset state, also while reset is held.
    #2;
    check_eq("rst_lready_during", 32'(l_ready), 32'd1);
    check_eq("rst_we_during", 32'(wb_we), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("rst_we", 32'(wb_we), 32'd0);
    check_eq("rst_addr", 32'(wb_addr), 32'd0);
    check_eq("rst_data", wb_data, 32'd0);
    check_eq("rst_iaddr", wb_iaddr, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_hold", 32'(pipe_hold), 32'd0);
    check_eq("rst_err", 32'(hold_err), 32'd0);
    check_eq("rst_lready", 32'(l_ready), 32'd1);

    // Pipeline write, one cycle latency; idle cycle holds the fields.
    p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h1234; p_pc = 32'h3000;
    tick();
    check_eq("p_we", 32'(wb_we), 32'd1);
    check_eq("p_addr", 32'(wb_addr), 32'd5);
    check_eq("p_data", wb_data, 32'h1234);
    check_eq("p_iaddr", wb_iaddr, 32'h3000);
    p_valid = 1'b0;
    tick();
    check_eq("idle_we", 32'(wb_we), 32'd0);
    check_eq("idle_addr_hold", 32'(wb_addr), 32'd5);
    check_eq("idle_data_hold", wb_data, 32'h1234);

    // Issue to r8, then long beat for r8: write two cycles after accept.
    iss_valid = 1'b1; iss_addr = 5'd8;
    tick();
    iss_valid = 1'b0;
    check_eq("iss_busy", busy, 32'h0000_0100);
    l_valid = 1'b1; l_addr = 5'd8; l_data = 32'hBEEF; l_pc = 32'h4000;
    check_eq("l_ready_empty", 32'(l_ready), 32'd1);
    tick();
    l_valid = 1'b0;
    check_eq("l_we_t1", 32'(wb_we), 32'd0);
    check_eq("l_busy_t1", busy, 32'h0000_0100);
    tick();
    check_eq("l_we_t2", 32'(wb_we), 32'd1);
    check_eq("l_addr_t2", 32'(wb_addr), 32'd8);
    check_eq("l_data_t2", wb_data, 32'hBEEF);
    check_eq("l_iaddr_t2", wb_iaddr, 32'h4000);
    check_eq("l_busy_t2", busy, 32'd0);

    // Fill FIFO under a live pipeline; starvation hold; drain in order.
    p_valid = 1'b1; p_addr = 5'd1; p_data = 32'h11; p_pc = 32'h100;
    for (int i = 0; i < 4; i++) begin
      l_valid = 1'b1; l_addr = 5'(10 + i); l_data = 32'hA0 + 32'(i); l_pc = 32'h600 + 32'(i);
      tick();
      check_eq("fill_pipe_wins", 32'(wb_addr), 32'd1);
    end
    check_eq("full_lready", 32'(l_ready), 32'd0);
    check_eq("full_no_hold_yet", 32'(pipe_hold), 32'd0);
    l_valid = 1'b1; l_addr = 5'd14; l_data = 32'hDEAD; l_pc = 32'h0;
    tick();
    check_eq("starve_hold", 32'(pipe_hold), 32'd1);
    p_valid = 1'b0; l_valid = 1'b0;
    tick();
    check_eq("hold_one_cycle", 32'(pipe_hold), 32'd0);
    check_eq("drain0_we", 32'(wb_we), 32'd1);
    check_eq("drain0_addr", 32'(wb_addr), 32'd10);
    check_eq("drain0_data", wb_data, 32'hA0);
    check_eq("drain0_iaddr", wb_iaddr, 32'h600);
    check_eq("drain_lready", 32'(l_ready), 32'd1);
    for (int j = 1; j < 4; j++) begin
      tick();
      check_eq("drain_addr", 32'(wb_addr), 32'(10 + j));
      check_eq("drain_data", wb_data, 32'hA0 + 32'(j));
    end
    tick();
    check_eq("drain_empty_we", 32'(wb_we), 32'd0);
    check_eq("no_err_yet", 32'(hold_err), 32'd0);

    // Pipeline stays live during hold: it still wins and hold_err sticks.
    p_valid = 1'b1; p_addr = 5'd3; p_data = 32'h33; p_pc = 32'h200;
    l_valid = 1'b1; l_addr = 5'd20; l_data = 32'h2020; l_pc = 32'h500;
    tick();
    l_valid = 1'b0;
    tick(); tick(); tick();
    check_eq("err_no_hold_yet", 32'(pipe_hold), 32'd0);
    tick();
    check_eq("err_hold", 32'(pipe_hold), 32'd1);
    p_data = 32'h44;
    tick();
    check_eq("err_set", 32'(hold_err), 32'd1);
    check_eq("err_pipe_we", 32'(wb_we), 32'd1);
    check_eq("err_pipe_addr", 32'(wb_addr), 32'd3);
    check_eq("err_pipe_data", wb_data, 32'h44);
    check_eq("err_hold_drop", 32'(pipe_hold), 32'd0);
    p_valid = 1'b0;
    tick();
    check_eq("err_drain_addr", 32'(wb_addr), 32'd20);
    check_eq("err_drain_data", wb_data, 32'h2020);
    check_eq("err_sticky", 32'(hold_err), 32'd1);

    // r0 on both channels: FIFO pops silently, pipeline is not live.
    p_valid = 1'b1; p_addr = 5'd0; p_data = 32'h66; p_pc = 32'h700;
    l_valid = 1'b1; l_addr = 5'd0; l_data = 32'h55; l_pc = 32'h800;
    tick();
    l_valid = 1'b0;
    check_eq("r0_pipe_we", 32'(wb_we), 32'd0);
    tick();
    check_eq("r0_pop_we", 32'(wb_we), 32'd0);
    check_eq("r0_addr_hold", 32'(wb_addr), 32'd20);
    check_eq("r0_data_hold", wb_data, 32'h2020);
    p_valid = 1'b0;
    tick();
    check_eq("r0_still_idle", 32'(wb_we), 32'd0);
    check_eq("r0_err_sticky", 32'(hold_err), 32'd1);

    // Three queued entries and busy bits, then asynchronous reset mid-cycle.
    for (int k = 0; k < 3; k++) begin
      iss_valid = 1'b1; iss_addr = 5'(8 + k);
      tick();
    end
    iss_valid = 1'b0;
    check_eq("q_busy", busy, 32'h0000_0700);
    p_valid = 1'b1; p_addr = 5'd4; p_data = 32'h99; p_pc = 32'h900;
    for (int k = 0; k < 3; k++) begin
      l_valid = 1'b1; l_addr = 5'(8 + k); l_data = 32'hC0 + 32'(k); l_pc = 32'h0;
      tick();
    end
    l_valid = 1'b0;
    check_eq("q_three_lready", 32'(l_ready), 32'd1);
    check_eq("q_pipe_we", 32'(wb_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_we", 32'(wb_we), 32'd0);
    check_eq("arst_busy", busy, 32'd0);
    check_eq("arst_addr", 32'(wb_addr), 32'd0);
    check_eq("arst_err", 32'(hold_err), 32'd0);
    check_eq("arst_lready", 32'(l_ready), 32'd1);
    p_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();
    check_eq("arst_fifo_empty_we", 32'(wb_we), 32'd0);
    check_eq("arst_busy_after", busy, 32'd0);

    // First beat after reset must be the head, proving old entries are gone.
    l_valid = 1'b1; l_addr = 5'd7; l_data = 32'h77; l_pc = 32'hA00;
    tick();
    l_valid = 1'b0;
    tick();
    check_eq("post_rst_addr", 32'(wb_addr), 32'd7);
    check_eq("post_rst_data", wb_data, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
